// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART.
//   - register byte offsets within the UART window
//   - bit positions inside the STATUS register
//   - uart_state_t, the state type used by both the TX and RX shifters
//   - MIN_DIVISOR and clampDivisor(), which keep the bit time long enough
//     for the receiver's half-bit count to be meaningful
package uart_pkg;

  localparam logic [3:0] UART_DATA    = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_DIVISOR = 4'h8;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_IDLE    = 1;
  localparam int STAT_RX_VALID   = 2;
  localparam int STAT_RX_OVERRUN = 3;
  localparam int STAT_FRAME_ERR  = 4;

  localparam logic [15:0] MIN_DIVISOR = 16'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] clampDivisor(input logic [15:0] value);
    return (value < MIN_DIVISOR) ? MIN_DIVISOR : value;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   push_i, data_i      write request and write data
//   pop_i               read request; data_o always shows the head entry
//   data_o              head entry (undefined content when empty_o is set)
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A pop frees the head slot in the same cycle, so a push into a full
  // FIFO is accepted whenever it is paired with a pop.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX/RX FIFOs.
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   address                       byte offset in the UART window ([1:0] ignored)
//   enable                        access strobe from the address decoder
//   write_enable, write_data      register write
//   read_enable, read_data        register read; read_data is registered
//   wait_o                        stall request, always 0 (named wait_o
//                                 because wait is a reserved word)
//   uart_rx                       asynchronous serial input
//   uart_tx                       serial output, idles high
// Registers: 0x0 DATA, 0x4 STATUS, 0x8 DIVISOR (clocks per bit).
module uart_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int DEFAULT_DIVISOR = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        wait_o,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int          CW            = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] RESET_DIVISOR = 16'(DEFAULT_DIVISOR);

  // Bus decode
  logic [3:0] regOffset;
  logic       busWrite, busRead;
  logic       dataWrite, statusWrite, divWrite, dataRead;
  logic       unusedInputs;

  assign regOffset   = {address[3:2], 2'b00};
  assign busWrite    = enable & write_enable;
  assign busRead     = enable & read_enable;
  assign dataWrite   = busWrite & (regOffset == UART_DATA);
  assign statusWrite = busWrite & (regOffset == UART_STATUS);
  assign divWrite    = busWrite & (regOffset == UART_DIVISOR);
  assign dataRead    = busRead  & (regOffset == UART_DATA);
  assign unusedInputs = ^{address[1:0], write_data[31:16]};

  // Register state
  logic [15:0] divisor_q, divisor_d;
  logic        overrun_q, overrun_d;
  logic        frameErr_q, frameErr_d;
  logic [31:0] readData_q, readData_d;
  logic [31:0] statusWord;

  // FIFO interfaces
  logic          txPop, txFull, txEmpty;
  logic [7:0]    txFifoData;
  logic [CW-1:0] txCount;
  logic          rxPush, rxPop, rxFull, rxEmpty;
  logic [7:0]    rxFifoData;
  logic [CW-1:0] rxCount;

  // TX shifter state
  uart_state_t txState_q, txState_d;
  logic [15:0] txCnt_q, txCnt_d;
  logic [15:0] txDiv_q, txDiv_d;
  logic [2:0]  txBit_q, txBit_d;
  logic [7:0]  txShift_q, txShift_d;
  logic        txLine_q, txLine_d;
  logic        txBitEnd, txIdle;

  // RX shifter state
  logic        rxSync1_q, rxSync2_q, rxPrev_q;
  uart_state_t rxState_q, rxState_d;
  logic [15:0] rxCnt_q, rxCnt_d;
  logic [15:0] rxDiv_q, rxDiv_d;
  logic [2:0]  rxBit_q, rxBit_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic        rxWaitHigh_q, rxWaitHigh_d;
  logic        rxBitEnd, rxHalfEnd, rxValid;
  logic        rxFrameErrSet, rxOverrunSet;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (dataWrite),
    .data_i  (write_data[7:0]),
    .pop_i   (txPop),
    .data_o  (txFifoData),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .count_o (txCount)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rxPush),
    .data_i  (rxShift_q),
    .pop_i   (rxPop),
    .data_o  (rxFifoData),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .count_o (rxCount)
  );

  assign wait_o    = 1'b0;
  assign read_data = readData_q;
  assign uart_tx   = txLine_q;

  assign txIdle  = (txCount == '0) && (txState_q == IDLE);
  assign rxValid = (rxCount != '0);
  assign rxPop   = dataRead & ~rxEmpty;

  // A push that finds the FIFO full is only lost if no pop frees a slot
  // in the same cycle.
  assign rxOverrunSet = rxPush & rxFull & ~rxPop;

  always_comb begin
    statusWord                  = '0;
    statusWord[STAT_TX_FULL]    = txFull;
    statusWord[STAT_TX_IDLE]    = txIdle;
    statusWord[STAT_RX_VALID]   = rxValid;
    statusWord[STAT_RX_OVERRUN] = overrun_q;
    statusWord[STAT_FRAME_ERR]  = frameErr_q;
  end

  // Register file: divisor, sticky flags (a new error wins over a
  // same-cycle clear), and the registered read port.
  always_comb begin
    divisor_d  = divisor_q;
    overrun_d  = overrun_q;
    frameErr_d = frameErr_q;
    readData_d = readData_q;
    if (divWrite) divisor_d = clampDivisor(write_data[15:0]);
    if (statusWrite && write_data[STAT_RX_OVERRUN]) overrun_d  = 1'b0;
    if (statusWrite && write_data[STAT_FRAME_ERR])  frameErr_d = 1'b0;
    if (rxOverrunSet)  overrun_d  = 1'b1;
    if (rxFrameErrSet) frameErr_d = 1'b1;
    if (busRead) begin
      case (regOffset)
        UART_DATA:    readData_d = rxEmpty ? 32'd0 : {1'b1, 23'd0, rxFifoData};
        UART_STATUS:  readData_d = statusWord;
        UART_DIVISOR: readData_d = {16'd0, divisor_q};
        default:      readData_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor_q  <= RESET_DIVISOR;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
      readData_q <= '0;
    end else begin
      divisor_q  <= divisor_d;
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
      readData_q <= readData_d;
    end
  end

  // TX shifter. The line is registered from the current state, so it lags
  // the state by one cycle; every bit still lasts exactly txDiv_q clocks.
  // STOP chains straight into START when another byte is waiting.
  assign txBitEnd = (txCnt_q == txDiv_q - 16'd1);

  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txDiv_d   = txDiv_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPop     = 1'b0;
    case (txState_q)
      IDLE: begin
        if (!txEmpty) begin
          txPop     = 1'b1;
          txShift_d = txFifoData;
          txDiv_d   = divisor_q;
          txCnt_d   = '0;
          txState_d = START;
        end
      end
      START: begin
        if (txBitEnd) begin
          txCnt_d   = '0;
          txBit_d   = '0;
          txState_d = DATA;
        end else begin
          txCnt_d = txCnt_q + 16'd1;
        end
      end
      DATA: begin
        if (txBitEnd) begin
          txCnt_d   = '0;
          txShift_d = {1'b0, txShift_q[7:1]};
          txBit_d   = txBit_q + 3'd1;
          if (txBit_q == 3'd7) txState_d = STOP;
        end else begin
          txCnt_d = txCnt_q + 16'd1;
        end
      end
      STOP: begin
        if (txBitEnd) begin
          txCnt_d = '0;
          if (!txEmpty) begin
            txPop     = 1'b1;
            txShift_d = txFifoData;
            txDiv_d   = divisor_q;
            txState_d = START;
          end else begin
            txState_d = IDLE;
          end
        end else begin
          txCnt_d = txCnt_q + 16'd1;
        end
      end
      default: txState_d = IDLE;
    endcase
    case (txState_q)
      START:   txLine_d = 1'b0;
      DATA:    txLine_d = txShift_q[0];
      default: txLine_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState_q <= IDLE;
      txCnt_q   <= '0;
      txDiv_q   <= RESET_DIVISOR;
      txBit_q   <= '0;
      txShift_q <= '0;
      txLine_q  <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txDiv_q   <= txDiv_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txLine_q  <= txLine_d;
    end
  end

  // RX shifter. A falling edge on the synchronised line starts a half-bit
  // count; from there every sample lands mid-bit. After a bad stop bit the
  // receiver stays in STOP until the line is high again, so a held-low line
  // cannot be mistaken for a new start bit.
  assign rxBitEnd  = (rxCnt_q == rxDiv_q - 16'd1);
  assign rxHalfEnd = (rxCnt_q == (rxDiv_q >> 1) - 16'd1);

  always_comb begin
    rxState_d     = rxState_q;
    rxCnt_d       = rxCnt_q;
    rxDiv_d       = rxDiv_q;
    rxBit_d       = rxBit_q;
    rxShift_d     = rxShift_q;
    rxWaitHigh_d  = rxWaitHigh_q;
    rxPush        = 1'b0;
    rxFrameErrSet = 1'b0;
    case (rxState_q)
      IDLE: begin
        if (rxPrev_q && !rxSync2_q) begin
          rxDiv_d   = divisor_q;
          rxCnt_d   = '0;
          rxState_d = START;
        end
      end
      START: begin
        if (rxHalfEnd) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxSync2_q ? IDLE : DATA;
        end else begin
          rxCnt_d = rxCnt_q + 16'd1;
        end
      end
      DATA: begin
        if (rxBitEnd) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync2_q, rxShift_q[7:1]};
          rxBit_d   = rxBit_q + 3'd1;
          if (rxBit_q == 3'd7) rxState_d = STOP;
        end else begin
          rxCnt_d = rxCnt_q + 16'd1;
        end
      end
      STOP: begin
        if (rxWaitHigh_q) begin
          if (rxSync2_q) begin
            rxWaitHigh_d = 1'b0;
            rxState_d    = IDLE;
          end
        end else if (rxBitEnd) begin
          rxCnt_d = '0;
          if (rxSync2_q) begin
            rxPush    = 1'b1;
            rxState_d = IDLE;
          end else begin
            rxFrameErrSet = 1'b1;
            rxWaitHigh_d  = 1'b1;
          end
        end else begin
          rxCnt_d = rxCnt_q + 16'd1;
        end
      end
      default: rxState_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxSync1_q    <= 1'b1;
      rxSync2_q    <= 1'b1;
      rxPrev_q     <= 1'b1;
      rxState_q    <= IDLE;
      rxCnt_q      <= '0;
      rxDiv_q      <= RESET_DIVISOR;
      rxBit_q      <= '0;
      rxShift_q    <= '0;
      rxWaitHigh_q <= 1'b0;
    end else begin
      rxSync1_q    <= uart_rx;
      rxSync2_q    <= rxSync1_q;
      rxPrev_q     <= rxSync2_q;
      rxState_q    <= rxState_d;
      rxCnt_q      <= rxCnt_d;
      rxDiv_q      <= rxDiv_d;
      rxBit_q      <= rxBit_d;
      rxShift_q    <= rxShift_d;
      rxWaitHigh_q <= rxWaitHigh_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: self-checking bench for uart_mmio.
// Bus accesses, serial frames and their expected results come from a small
// behavioural model: a byte queue standing in for the RX FIFO plus two
// sticky error bits, and frame shapes derived from the 8N1 format.
module tb_uart_mmio;

  localparam logic [3:0] ADDR_DATA    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_DIVISOR = 4'h8;
  localparam int         DEPTH        = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        enable;
  logic        write_enable;
  logic [31:0] write_data;
  logic        read_enable;
  logic [31:0] read_data;
  logic        waitSig;
  logic        uart_rx;
  logic        uart_tx;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] rxModel [$];
  bit         modelOverrun  = 1'b0;
  bit         modelFrameErr = 1'b0;

  always #5 clk = ~clk;

  uart_mmio #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(434)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .enable       (enable),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .wait_o       (waitSig),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx)
  );

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    address      = addr;
    write_data   = data;
    enable       = 1'b1;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    enable       = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    address     = addr;
    enable      = 1'b1;
    read_enable = 1'b1;
    @(posedge clk);
    #1;
    data        = read_data;
    enable      = 1'b0;
    read_enable = 1'b0;
  endtask

  // Drives one 8N1 frame on uart_rx, each bit held div clocks.
  task automatic applyStimulus(input logic [7:0] value, input bit stopBit, input int div);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = value[i];
      repeat (div) @(negedge clk);
    end
    uart_rx = stopBit;
    repeat (div) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic sendRxByte(input logic [7:0] value, input bit stopBit, input int div);
    applyStimulus(value, stopBit, div);
    if (!stopBit)                    modelFrameErr = 1'b1;
    else if (rxModel.size() < DEPTH) rxModel.push_back(value);
    else                             modelOverrun = 1'b1;
  endtask

  function automatic logic [31:0] expectedStatus(input bit txIdle, input bit txFull);
    return {27'd0, modelFrameErr, modelOverrun, rxModel.size() != 0, txIdle, txFull};
  endfunction

  task automatic checkDataRead(input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    busRead(ADDR_DATA, rd);
    if (rxModel.size() != 0) exp = {1'b1, 23'd0, rxModel.pop_front()};
    else                     exp = 32'd0;
    checkOutput(tag, rd, exp);
  endtask

  // Waits (bounded) for a start bit, then samples each bit at its middle.
  task automatic captureFrame(input int div, input int bound, output logic [7:0] data,
                              output bit stopBit, output bit ok);
    int waited = 0;
    data    = '0;
    stopBit = 1'b0;
    while (uart_tx !== 1'b0 && waited < bound) begin
      waitCycles(1);
      waited++;
    end
    ok = (uart_tx === 1'b0);
    if (ok) begin
      waitCycles(div / 2);
      for (int i = 0; i < 8; i++) begin
        waitCycles(div);
        data[i] = uart_tx;
      end
      waitCycles(div);
      stopBit = uart_tx;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  capData;
    bit          capStop;
    bit          capOk;
    int          div;
    int          polls;
    logic [7:0]  b;
    logic [9:0]  frameBits;
    logic [39:0] obsWave;
    logic [39:0] expWave;
    int          divVals [4];
    logic [7:0]  txBytes [18];

    reset        = 1'b1;
    address      = '0;
    enable       = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    read_enable  = 1'b0;
    uart_rx      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset defaults");
    checkOutput("reset_uart_tx", uart_tx, 1);
    checkOutput("reset_read_data", read_data, 0);
    checkOutput("reset_wait", waitSig, 0);
    busRead(ADDR_STATUS, rd);
    checkOutput("reset_status", rd, expectedStatus(1'b1, 1'b0));
    busRead(ADDR_DIVISOR, rd);
    checkOutput("reset_divisor", rd, 434);
    busRead(4'hC, rd);
    checkOutput("unmapped_read", rd, 0);

    $display("[TB] divisor clamp");
    divVals[0] = 3;
    divVals[1] = 4;
    divVals[2] = int'($urandom_range(0, 20));
    divVals[3] = int'($urandom_range(0, 20));
    foreach (divVals[i]) begin
      busWrite(ADDR_DIVISOR, divVals[i]);
      busRead(ADDR_DIVISOR, rd);
      checkOutput("divisor_clamp", rd, (divVals[i] < 4) ? 4 : divVals[i]);
    end

    $display("[TB] tx frame 0xA5");
    busWrite(ADDR_DIVISOR, 4);
    busWrite(ADDR_DATA, 32'hA5);
    waitCycles(1);
    checkOutput("tx_latency_one_cycle", uart_tx, 1);
    waitCycles(1);
    frameBits = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      obsWave[k] = uart_tx;
      expWave[k] = frameBits[k / 4];
      waitCycles(1);
    end
    checkOutput("tx_wave_A5", obsWave, expWave);
    polls = 0;
    busRead(ADDR_STATUS, rd);
    while (rd[1] !== 1'b1 && polls < 20) begin
      busRead(ADDR_STATUS, rd);
      polls++;
    end
    checkOutput("tx_idle_after_frame", rd, expectedStatus(1'b1, 1'b0));

    $display("[TB] rx frame 0x3C");
    sendRxByte(8'h3C, 1'b1, 4);
    busRead(ADDR_STATUS, rd);
    checkOutput("rx_status_valid", rd, expectedStatus(1'b1, 1'b0));
    checkDataRead("rx_data_3C");
    checkDataRead("rx_data_empty");

    $display("[TB] framing error");
    sendRxByte(8'h55, 1'b0, 4);
    busRead(ADDR_STATUS, rd);
    checkOutput("frame_err_status", rd, expectedStatus(1'b1, 1'b0));
    checkDataRead("frame_err_no_data");
    busWrite(ADDR_STATUS, 32'h10);
    modelFrameErr = 1'b0;
    busRead(ADDR_STATUS, rd);
    checkOutput("frame_err_cleared", rd, expectedStatus(1'b1, 1'b0));

    $display("[TB] random tx/rx frames");
    for (int i = 0; i < 4; i++) begin
      div = int'($urandom_range(4, 8));
      busWrite(ADDR_DIVISOR, div);
      b = 8'($urandom);
      busWrite(ADDR_DATA, {24'd0, b});
      captureFrame(div, 40, capData, capStop, capOk);
      checkOutput("rand_tx_found", capOk, 1);
      checkOutput("rand_tx_byte", capData, b);
      checkOutput("rand_tx_stop", capStop, 1);
      sendRxByte(8'($urandom), 1'b1, div);
      checkDataRead("rand_rx_byte");
    end

    $display("[TB] rx overrun");
    busWrite(ADDR_DIVISOR, 4);
    for (int i = 0; i < DEPTH + 1; i++) sendRxByte(8'($urandom), 1'b1, 4);
    busRead(ADDR_STATUS, rd);
    checkOutput("overrun_status", rd, expectedStatus(1'b1, 1'b0));
    for (int i = 0; i < DEPTH; i++) checkDataRead("overrun_fifo_order");
    checkDataRead("overrun_drained");
    busWrite(ADDR_STATUS, 32'h08);
    modelOverrun = 1'b0;
    busRead(ADDR_STATUS, rd);
    checkOutput("overrun_cleared", rd, expectedStatus(1'b1, 1'b0));

    $display("[TB] tx full");
    foreach (txBytes[i]) txBytes[i] = 8'($urandom);
    fork
      begin
        logic [31:0] st;
        foreach (txBytes[i]) busWrite(ADDR_DATA, {24'd0, txBytes[i]});
        busRead(ADDR_STATUS, st);
        checkOutput("tx_full_status", st, expectedStatus(1'b0, 1'b1));
      end
      begin
        logic [7:0] fData;
        bit         fStop;
        bit         fOk;
        for (int f = 0; f < DEPTH + 1; f++) begin
          captureFrame(4, 200, fData, fStop, fOk);
          checkOutput("tx_full_frame_found", fOk, 1);
          checkOutput("tx_full_frame_byte", fData, txBytes[f]);
          checkOutput("tx_full_frame_stop", fStop, 1);
        end
      end
    join
    captureFrame(4, 120, capData, capStop, capOk);
    checkOutput("tx_full_no_extra_frame", capOk, 0);
    busRead(ADDR_STATUS, rd);
    checkOutput("tx_full_idle", rd, expectedStatus(1'b1, 1'b0));

    $display("[TB] reset mid-frame");
    busWrite(ADDR_DATA, 32'h00);
    waitCycles(3);
    checkOutput("abort_line_low", uart_tx, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_line_async_high", uart_tx, 1);
    @(negedge clk);
    reset = 1'b0;
    rxModel.delete();
    modelOverrun  = 1'b0;
    modelFrameErr = 1'b0;
    busRead(ADDR_STATUS, rd);
    checkOutput("abort_status", rd, expectedStatus(1'b1, 1'b0));
    busRead(ADDR_DIVISOR, rd);
    checkOutput("abort_divisor", rd, 434);
    captureFrame(4, 60, capData, capStop, capOk);
    checkOutput("abort_no_frame", capOk, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
